// File: rtl/cursor_controller_if.sv
// Button/occupancy inputs and cursor/select outputs of the cursor controller.
// The testbench or game logic drives through master; the controller uses slave.
interface cursor_controller_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_sel;
  logic       enable;
  logic [8:0] occupied;
  logic [3:0] sel_position;
  logic       select_valid;
  logic [3:0] select_index;
  logic       select_reject;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_sel, enable, occupied,
    input  sel_position, select_valid, select_index, select_reject
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_sel, enable, occupied,
    output sel_position, select_valid, select_index, select_reject
  );
endinterface

// File: rtl/cursor_controller.sv
// Converts raw push-buttons into a wrapping 3x3 cursor index with auto-repeat,
// and gates cell selects against the occupancy mask.
module cursor_controller #(
  parameter int unsigned HOLD_CYCLES   = 12500000,
  parameter int unsigned REPEAT_CYCLES = 5000000,
  parameter int unsigned RESET_POS     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cursor_controller_if.slave   bus
);

  localparam int unsigned     CNT_W       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [1:0]      RESET_COL   = 2'(RESET_POS / 3);
  localparam logic [1:0]      RESET_ROW   = 2'(RESET_POS % 3);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} state_t;
  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  function automatic logic [3:0] cell_index(input logic [1:0] col, input logic [1:0] row);
    return ({2'b00, col} << 1) + {2'b00, col} + {2'b00, row};
  endfunction

  // Button vector bit order: 0 up, 1 down, 2 left, 3 right, 4 select.
  logic [4:0] raw;
  logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, armed_q, armed_d;
  logic [1:0] fill_q, fill_d;
  state_t     state_q, state_d;
  dir_t       held_dir_q, held_dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] col_q, col_d, row_q, row_d;
  logic [3:0] sel_position_q, sel_position_d;
  logic       select_valid_q, select_valid_d, select_reject_q, select_reject_d;
  logic [3:0] select_index_q, select_index_d;

  logic [4:0] press;
  dir_t       active_dir;
  logic       active_press;
  logic       do_move;

  assign raw = {bus.btn_sel, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  assign bus.sel_position  = sel_position_q;
  assign bus.select_valid  = select_valid_q;
  assign bus.select_index  = select_index_q;
  assign bus.select_reject = select_reject_q;

  // Synchroniser, edge detect, active direction and repeat FSM next state.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fill_d  = {fill_q[0], 1'b1};
    // A button held through reset must be seen released before it can press.
    armed_d = armed_q | (~sync2_q & {5{fill_q[1]}});
    press   = sync2_q & ~prev_q & armed_q;

    if (sync2_q[0]) begin
      active_dir = DIR_UP;
    end else if (sync2_q[1]) begin
      active_dir = DIR_DOWN;
    end else if (sync2_q[2]) begin
      active_dir = DIR_LEFT;
    end else if (sync2_q[3]) begin
      active_dir = DIR_RIGHT;
    end else begin
      active_dir = DIR_NONE;
    end

    case (active_dir)
      DIR_UP:    active_press = press[0];
      DIR_DOWN:  active_press = press[1];
      DIR_LEFT:  active_press = press[2];
      DIR_RIGHT: active_press = press[3];
      default:   active_press = 1'b0;
    endcase

    state_d    = state_q;
    held_dir_d = held_dir_q;
    cnt_d      = cnt_q;
    do_move    = 1'b0;
    if (!bus.enable) begin
      state_d    = ST_IDLE;
      held_dir_d = DIR_NONE;
      cnt_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (active_press) begin
            do_move    = 1'b1;
            cnt_d      = '0;
            state_d    = ST_HELD;
            held_dir_d = active_dir;
          end else begin
            cnt_d = '0;
          end
        end
        ST_HELD: begin
          if (active_dir != held_dir_q) begin
            state_d    = ST_IDLE;
            held_dir_d = DIR_NONE;
            cnt_d      = '0;
          end else if (cnt_q == HOLD_LAST) begin
            do_move = 1'b1;
            cnt_d   = '0;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (active_dir != held_dir_q) begin
            state_d    = ST_IDLE;
            held_dir_d = DIR_NONE;
            cnt_d      = '0;
          end else if (cnt_q == REPEAT_LAST) begin
            do_move = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d    = ST_IDLE;
          held_dir_d = DIR_NONE;
          cnt_d      = '0;
        end
      endcase
    end
  end

  // Cursor move with wrap, registered index, and select gating.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (do_move) begin
      case (active_dir)
        DIR_UP:    row_d = (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;
        DIR_DOWN:  row_d = (row_q >= 2'd2) ? 2'd0 : row_q + 2'd1;
        DIR_LEFT:  col_d = (col_q == 2'd0) ? 2'd2 : col_q - 2'd1;
        DIR_RIGHT: col_d = (col_q >= 2'd2) ? 2'd0 : col_q + 2'd1;
        default: begin
          col_d = col_q;
          row_d = row_q;
        end
      endcase
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
    sel_position_d = cell_index(col_d, row_d);

    // Select checks the cursor as it stood before any same-cycle move.
    select_valid_d  = 1'b0;
    select_reject_d = 1'b0;
    select_index_d  = select_index_q;
    if (bus.enable && press[4]) begin
      if (bus.occupied[sel_position_q]) begin
        select_reject_d = 1'b1;
      end else begin
        select_valid_d = 1'b1;
        select_index_d = sel_position_q;
      end
    end else begin
      select_index_d = select_index_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q         <= 5'b00000;
      sync2_q         <= 5'b00000;
      prev_q          <= 5'b00000;
      armed_q         <= 5'b00000;
      fill_q          <= 2'b00;
      state_q         <= ST_IDLE;
      held_dir_q      <= DIR_NONE;
      cnt_q           <= '0;
      col_q           <= RESET_COL;
      row_q           <= RESET_ROW;
      sel_position_q  <= cell_index(RESET_COL, RESET_ROW);
      select_valid_q  <= 1'b0;
      select_reject_q <= 1'b0;
      select_index_q  <= 4'd0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      prev_q          <= prev_d;
      armed_q         <= armed_d;
      fill_q          <= fill_d;
      state_q         <= state_d;
      held_dir_q      <= held_dir_d;
      cnt_q           <= cnt_d;
      col_q           <= col_d;
      row_q           <= row_d;
      sel_position_q  <= sel_position_d;
      select_valid_q  <= select_valid_d;
      select_reject_q <= select_reject_d;
      select_index_q  <= select_index_d;
    end
  end

endmodule

// File: tb/tb_cursor_controller.sv
// Self-checking bench for cursor_controller: tap table, auto-repeat, priority,
// select gating, enable and mid-repeat reset, scored through an expectation queue.
module tb_cursor_controller;

  logic clk;
  logic rst_n;
  cursor_controller_if bus ();

  cursor_controller #(
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .RESET_POS    (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench button order: 0 up, 1 down, 2 left, 3 right, 4 select.
  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_UP    = 5'b00001;
  localparam logic [4:0] B_DOWN  = 5'b00010;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b01000;
  localparam logic [4:0] B_SEL   = 5'b10000;

  typedef struct packed {
    int         due;
    logic [3:0] pos;
    logic       v;
    logic       r;
    logic [3:0] idx;
    logic       chk_idx;
  } exp_t;

  typedef struct packed {
    logic [4:0] btn;
    logic [3:0] exp_pos;
  } tap_vec_t;

  exp_t       sb[$];
  tap_vec_t   taps[5];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  string      phase    = "init";
  logic [3:0] cur_pos;
  int         rep_t[6];
  logic [3:0] rep_p[6];

  function automatic exp_t mk(input int due, input logic [3:0] pos, input logic v,
                              input logic r, input logic [3:0] idx, input logic chk_idx);
    exp_t e;
    e.due = due; e.pos = pos; e.v = v; e.r = r; e.idx = idx; e.chk_idx = chk_idx;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    checks++;
    if (bus.sel_position !== e.pos || bus.select_valid !== e.v || bus.select_reject !== e.r ||
        (e.chk_idx && bus.select_index !== e.idx)) begin
      failures++;
      $display("FAIL %s cyc=%0d: got pos=%0d valid=%b reject=%b index=%0d, expected pos=%0d valid=%b reject=%b index=%0d",
               phase, cyc, bus.sel_position, bus.select_valid, bus.select_reject, bus.select_index,
               e.pos, e.v, e.r, e.idx);
    end
  endtask

  task automatic push(input int due, input logic [3:0] pos, input logic v, input logic r);
    sb.push_back(mk(due, pos, v, r, 4'd0, 1'b0));
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      compare(e);
    end
  endtask

  task automatic drive_btn(input logic [4:0] b);
    bus.btn_up    = b[0];
    bus.btn_down  = b[1];
    bus.btn_left  = b[2];
    bus.btn_right = b[3];
    bus.btn_sel   = b[4];
  endtask

  // One-cycle tap: old value until 2 edges after driving, new value on the 3rd.
  task automatic tap(input logic [4:0] b, input logic [3:0] new_pos);
    int d;
    d = cyc;
    push(d + 2, cur_pos, 1'b0, 1'b0);
    push(d + 3, new_pos, 1'b0, 1'b0);
    drive_btn(b);
    tick();
    drive_btn(B_NONE);
    repeat (6) tick();
    compare(mk(cyc, new_pos, 1'b0, 1'b0, 4'd0, 1'b0));
    cur_pos = new_pos;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, cyc=%0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int d;
    logic [3:0] p;

    taps[0] = '{btn: B_RIGHT, exp_pos: 4'd7};
    taps[1] = '{btn: B_RIGHT, exp_pos: 4'd1};
    taps[2] = '{btn: B_UP,    exp_pos: 4'd0};
    taps[3] = '{btn: B_UP,    exp_pos: 4'd2};
    taps[4] = '{btn: B_DOWN,  exp_pos: 4'd0};
    rep_t = '{3, 11, 15, 19, 23, 27};
    rep_p = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};

    rst_n = 1'b0;
    drive_btn(B_NONE);
    bus.enable   = 1'b1;
    bus.occupied = 9'b000000000;

    phase = "reset";
    repeat (2) tick();
    compare(mk(cyc, 4'd4, 1'b0, 1'b0, 4'd0, 1'b1));
    rst_n = 1'b1;
    phase = "idle_after_reset";
    for (int i = 0; i < 100; i++) begin
      tick();
      compare(mk(cyc, 4'd4, 1'b0, 1'b0, 4'd0, 1'b1));
    end
    cur_pos = 4'd4;

    phase = "tap_table";
    for (int i = 0; i < 5; i++) tap(taps[i].btn, taps[i].exp_pos);

    // Hold down 28 cycles from 0: moves at press, +8, then every 4.
    phase = "auto_repeat";
    d = cyc;
    for (int t = 1; t <= 40; t++) begin
      p = 4'd0;
      for (int k = 0; k < 6; k++) if (t >= rep_t[k]) p = rep_p[k];
      push(d + t, p, 1'b0, 1'b0);
    end
    drive_btn(B_DOWN);
    repeat (28) tick();
    drive_btn(B_NONE);
    repeat (12) tick();
    cur_pos = 4'd0;

    phase = "prio_setup";
    tap(B_RIGHT, 4'd3);
    tap(B_DOWN, 4'd4);

    phase = "priority";
    d = cyc;
    push(d + 2, 4'd4, 1'b0, 1'b0);
    push(d + 3, 4'd3, 1'b0, 1'b0);
    drive_btn(B_UP | B_LEFT);
    repeat (3) tick();
    for (int t = 4; t <= 24; t++) push(d + t, 4'd3, 1'b0, 1'b0);
    drive_btn(B_LEFT);
    repeat (17) tick();
    drive_btn(B_NONE);
    repeat (4) tick();
    cur_pos = 4'd3;
    phase = "left_repress";
    tap(B_LEFT, 4'd0);

    phase = "sel_setup";
    tap(B_RIGHT, 4'd3);
    tap(B_DOWN, 4'd4);
    bus.occupied = 9'b000010000;

    phase = "sel_reject";
    d = cyc;
    push(d + 2, 4'd4, 1'b0, 1'b0);
    push(d + 3, 4'd4, 1'b0, 1'b1);
    push(d + 4, 4'd4, 1'b0, 1'b0);
    drive_btn(B_SEL);
    tick();
    drive_btn(B_NONE);
    repeat (5) tick();

    phase = "sel_move";
    tap(B_DOWN, 4'd5);

    phase = "sel_valid";
    d = cyc;
    sb.push_back(mk(d + 2, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0));
    sb.push_back(mk(d + 3, 4'd5, 1'b1, 1'b0, 4'd5, 1'b1));
    sb.push_back(mk(d + 4, 4'd5, 1'b0, 1'b0, 4'd5, 1'b1));
    drive_btn(B_SEL);
    tick();
    drive_btn(B_NONE);
    repeat (5) tick();

    phase = "sel_hold";
    d = cyc;
    for (int t = 1; t <= 25; t++) push(d + t, 4'd5, (t == 3), 1'b0);
    drive_btn(B_SEL);
    repeat (20) tick();
    drive_btn(B_NONE);
    repeat (5) tick();

    phase = "enable_low";
    bus.enable = 1'b0;
    d = cyc;
    for (int t = 1; t <= 10; t++) push(d + t, 4'd5, 1'b0, 1'b0);
    drive_btn(B_RIGHT | B_SEL);
    tick();
    drive_btn(B_NONE);
    repeat (9) tick();
    bus.enable = 1'b1;
    repeat (3) tick();
    compare(mk(cyc, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0));

    // Hold down from 5 into REPEAT, then reset while still held.
    phase = "reset_mid_repeat";
    d = cyc;
    for (int t = 1; t <= 21; t++) begin
      if (t >= 19)      p = 4'd3;
      else if (t >= 15) p = 4'd5;
      else if (t >= 11) p = 4'd4;
      else if (t >= 3)  p = 4'd3;
      else              p = 4'd5;
      push(d + t, p, 1'b0, 1'b0);
    end
    drive_btn(B_DOWN);
    repeat (21) tick();
    rst_n = 1'b0;
    sb.push_back(mk(d + 22, 4'd4, 1'b0, 1'b0, 4'd0, 1'b1));
    sb.push_back(mk(d + 23, 4'd4, 1'b0, 1'b0, 4'd0, 1'b1));
    repeat (2) tick();
    rst_n = 1'b1;
    phase = "held_through_reset";
    for (int t = 24; t <= 50; t++) push(d + t, 4'd4, 1'b0, 1'b0);
    repeat (27) tick();
    drive_btn(B_NONE);
    repeat (5) tick();
    cur_pos = 4'd4;
    phase = "repress_after_reset";
    tap(B_DOWN, 4'd5);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
